// File: rtl/mfp_ahb_frame_pacer.sv
// AHB-Lite frame pacer: divides HCLK into ticks, counts ticks to a programmable period and raises
// a sticky frame-pending flag, a registered interrupt and a saturating overrun count per frame.

module mfp_ahb_frame_pacer #(
  parameter int unsigned DIV        = 3,
  parameter int unsigned PERIOD_W   = 24,
  parameter int unsigned PERIOD_RST = 416667
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [3:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        frame_tick,
  output logic        frame_irq
);

  localparam int unsigned PrescW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(DIV - 1);

  typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

  state_e              state_q, state_d;
  logic [1:0]          addr_q, addr_d;
  logic                wr_q, wr_d;
  logic                en_q, en_d;
  logic                irq_en_q, irq_en_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pend_q, pend_d;
  logic [7:0]          ovr_q, ovr_d;
  logic [15:0]         fcnt_q, fcnt_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] act_q, act_d;
  logic                tick_q, tick_d;
  logic                irq_q, irq_d;
  logic [31:0]         rdata_q, rdata_d;

  logic we_ctrl, we_period, clr_pend, clr_ovr, frame_evt;
  logic unused_bits;

  assign unused_bits = ^{HADDR[1:0], HWDATA};

  always_comb begin
    addr_d    = HADDR[3:2];
    wr_d      = HSEL & HWRITE & (HTRANS != 2'b00);
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    period_d  = period_q;
    pend_d    = pend_q;
    ovr_d     = ovr_q;
    fcnt_d    = fcnt_q;
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
    frame_evt = 1'b0;

    // Write decode uses the address phase captured one cycle earlier, aligned with HWDATA.
    we_ctrl   = wr_q & (addr_q == 2'd0);
    we_period = wr_q & (addr_q == 2'd1);
    clr_pend  = wr_q & (addr_q == 2'd2) & HWDATA[0];
    clr_ovr   = wr_q & (addr_q == 2'd2) & HWDATA[1];

    if (we_ctrl) begin
      en_d     = HWDATA[0];
      irq_en_d = HWDATA[1];
    end
    if (we_period) begin
      period_d = HWDATA[PERIOD_W-1:0];
    end

    unique case (state_q)
      StIdle: begin
        presc_d = '0;
        cnt_d   = '0;
        if (en_q && (period_q != '0)) state_d = StArm;
      end
      StArm: begin
        act_d   = period_q;
        presc_d = '0;
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        if (!en_q || (act_q == '0)) begin
          state_d = StIdle;
          presc_d = '0;
          cnt_d   = '0;
        end else if (presc_q == PrescLast) begin
          presc_d = '0;
          if (cnt_q == act_q - PERIOD_W'(1)) begin
            // A new PERIOD only takes effect here, at the frame wrap.
            cnt_d     = '0;
            act_d     = period_q;
            frame_evt = 1'b1;
          end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
          end
        end else begin
          presc_d = presc_q + PrescW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr_pend) pend_d = 1'b0;
    if (clr_ovr)  ovr_d  = 8'd0;
    // Clears apply before the frame event; the set of PEND wins, a cleared OVERRUN stays 0.
    if (frame_evt) begin
      fcnt_d = fcnt_q + 16'd1;
      if (pend_q && !clr_pend && !clr_ovr && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
      pend_d = 1'b1;
    end

    tick_d = frame_evt;
    irq_d  = pend_q & irq_en_q;

    case (HADDR[3:2])
      2'd0:    rdata_d = {30'd0, irq_en_q, en_q};
      2'd1:    rdata_d = 32'(period_q);
      2'd2:    rdata_d = {16'd0, ovr_q, 7'd0, pend_q};
      default: rdata_d = {16'd0, fcnt_q};
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      addr_q   <= 2'd0;
      wr_q     <= 1'b0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      period_q <= PERIOD_W'(PERIOD_RST);
      pend_q   <= 1'b0;
      ovr_q    <= 8'd0;
      fcnt_q   <= 16'd0;
      presc_q  <= '0;
      cnt_q    <= '0;
      act_q    <= '0;
      tick_q   <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      period_q <= period_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      fcnt_q   <= fcnt_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      tick_q   <= tick_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign HRDATA     = rdata_q;
  assign frame_tick = tick_q;
  assign frame_irq  = irq_q;

endmodule

// File: tb/tb_mfp_ahb_frame_pacer.sv
// Randomised bench for mfp_ahb_frame_pacer: frame timing, PEND/OVERRUN/FRAME_CNT against a
// tick-driven reference model, W1C collisions, period change, EN toggling and async reset.

module tb_mfp_ahb_frame_pacer;

  localparam int unsigned Div       = 3;
  localparam int unsigned PeriodW   = 24;
  localparam int unsigned PeriodRst = 416667;

  logic        HCLK;
  logic        HRESETn;
  logic [3:0]  HADDR;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HRDATA;
  logic        frame_tick;
  logic        frame_irq;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state, advanced once per observed frame_tick.
  int         clr_cyc  = -1;
  logic [1:0] clr_bits = 2'b00;
  int         ticks_m  = 0;
  logic       pend_m   = 1'b0;
  int         ovr_m    = 0;

  mfp_ahb_frame_pacer #(
    .DIV       (Div),
    .PERIOD_W  (PeriodW),
    .PERIOD_RST(PeriodRst)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWDATA    (HWDATA),
    .HWRITE    (HWRITE),
    .HSEL      (HSEL),
    .HRDATA    (HRDATA),
    .frame_tick(frame_tick),
    .frame_irq (frame_irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(negedge HCLK or negedge HRESETn) begin : model
    logic p;
    int   o;
    logic clr_now;
    if (!HRESETn) begin
      ticks_m <= 0;
      pend_m  <= 1'b0;
      ovr_m   <= 0;
    end else begin
      clr_now = (clr_cyc == cyc);
      p = pend_m;
      o = ovr_m;
      if (clr_now && clr_bits[0]) p = 1'b0;
      if (clr_now && clr_bits[1]) o = 0;
      if (frame_tick === 1'b1) begin
        if (p && !(clr_now && clr_bits[1])) o = (o < 255) ? o + 1 : 255;
        p = 1'b1;
        ticks_m <= ticks_m + 1;
      end
      pend_m <= p;
      ovr_m  <= o;
    end
  end

  function automatic logic [31:0] status_exp();
    logic [31:0] v;
    v       = 32'd0;
    v[15:8] = ovr_m[7:0];
    v[0]    = pend_m;
    return v;
  endfunction

  function automatic logic [31:0] fcnt_exp();
    logic [31:0] v;
    v = 32'(ticks_m) & 32'h0000_FFFF;
    return v;
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    HSEL   = 1'b1;
    HWRITE = 1'b1;
    HTRANS = 2'b10;
    HADDR  = a;
    tick();
    HWDATA = d;
    HSEL   = 1'b0;
    HWRITE = 1'b0;
    HTRANS = 2'b00;
    tick();
    if (a == 4'h8) begin
      clr_cyc  = cyc;
      clr_bits = d[1:0];
    end
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    HSEL   = 1'b1;
    HWRITE = 1'b0;
    HTRANS = 2'b10;
    HADDR  = a;
    tick();
    d      = HRDATA;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
  endtask

  task automatic wait_tick(input int bound, output int t);
    logic done;
    t    = -1;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      tick();
      if (frame_tick === 1'b1) begin
        t    = cyc;
        done = 1'b1;
      end
    end
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(posedge HCLK);
    #1;
    n_checks++;
    if (HRDATA !== 32'd0) $display("FAIL rst_hrdata: got %0h want 0", HRDATA); else n_pass++;
    n_checks++;
    if (frame_tick !== 1'b0) $display("FAIL rst_tick: got %b want 0", frame_tick); else n_pass++;
    n_checks++;
    if (frame_irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", frame_irq); else n_pass++;
    HRESETn = 1'b1;
    tick();
    bus_read(4'h0, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL rst_ctrl: got %0h want 0", d); else n_pass++;
    bus_read(4'h4, d);
    n_checks++;
    if (d !== 32'(PeriodRst)) $display("FAIL rst_period: got %0d want %0d", d, PeriodRst);
    else n_pass++;
    bus_read(4'h8, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL rst_status: got %0h want 0", d); else n_pass++;
    bus_read(4'hC, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL rst_fcnt: got %0h want 0", d); else n_pass++;
  endtask

  task automatic test_frame_rate();
    int p, e, t;
    logic [31:0] d;
    for (int it = 0; it < 3; it++) begin
      p = $urandom_range(1, 5);
      bus_write(4'h4, 32'(p));
      bus_write(4'h0, 32'h1);
      e = cyc + 2 + p * Div;
      for (int k = 0; k < 3; k++) begin
        wait_tick(p * Div + 8, t);
        n_checks++;
        if (t !== e) $display("FAIL rate_tick_time: got cycle %0d want %0d (P=%0d)", t, e, p);
        else n_pass++;
        bus_read(4'hC, d);
        n_checks++;
        if (d !== fcnt_exp()) $display("FAIL rate_fcnt: got %0d want %0d", d, fcnt_exp());
        else n_pass++;
        e = e + p * Div;
      end
      bus_write(4'h0, 32'h0);
      bus_write(4'h8, 32'h3);
      repeat (4) tick();
    end
  endtask

  task automatic test_overrun();
    int p, e, t;
    logic [31:0] d;
    bus_write(4'h8, 32'h3);
    p = $urandom_range(2, 4);
    bus_write(4'h4, 32'(p));
    bus_write(4'h0, 32'h1);
    e = cyc + 2 + p * Div;
    for (int k = 0; k < 3; k++) begin
      wait_tick(p * Div + 8, t);
      n_checks++;
      if (t !== e) $display("FAIL ovr_tick_time: got cycle %0d want %0d", t, e); else n_pass++;
      e = e + p * Div;
    end
    bus_read(4'h8, d);
    n_checks++;
    if (d !== status_exp()) $display("FAIL ovr_status: got %0h want %0h", d, status_exp());
    else n_pass++;
    n_checks++;
    if (d[15:8] !== 8'd2) $display("FAIL ovr_count3: got %0d want 2", d[15:8]); else n_pass++;
    bus_write(4'h8, 32'h3);
    bus_read(4'h8, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL ovr_cleared: got %0h want 0", d); else n_pass++;
    // Run ~300 short frames with PEND never cleared to reach saturation.
    bus_write(4'h4, 32'h1);
    wait_until(cyc + 900);
    bus_read(4'h8, d);
    n_checks++;
    if (d !== status_exp()) $display("FAIL ovr_sat_status: got %0h want %0h", d, status_exp());
    else n_pass++;
    n_checks++;
    if (d[15:8] !== 8'hFF) $display("FAIL ovr_sat: got %0d want 255", d[15:8]); else n_pass++;
    bus_write(4'h0, 32'h0);
    bus_write(4'h8, 32'h3);
    repeat (4) tick();
  endtask

  task automatic test_w1c_collision();
    int p, e, t;
    logic [31:0] d;
    bus_write(4'h8, 32'h3);
    p = $urandom_range(2, 5);
    bus_write(4'h4, 32'(p));
    bus_write(4'h0, 32'h1);
    e = cyc + 2 + p * Div;
    wait_tick(p * Div + 8, t);
    n_checks++;
    if (t !== e) $display("FAIL w1c_first_tick: got cycle %0d want %0d", t, e); else n_pass++;
    // Land the PEND clear on the very edge of the next frame event.
    e = t + p * Div;
    wait_until(e - 2);
    bus_write(4'h8, 32'h1);
    n_checks++;
    if (frame_tick !== 1'b1) $display("FAIL w1c_pend_align: got %b want 1", frame_tick);
    else n_pass++;
    bus_read(4'h8, d);
    n_checks++;
    if (d !== status_exp()) $display("FAIL w1c_pend: got %0h want %0h", d, status_exp());
    else n_pass++;
    n_checks++;
    if (d !== 32'h1) $display("FAIL w1c_pend_value: got %0h want 1", d); else n_pass++;
    e = e + 2 * p * Div;
    wait_until(e - 2);
    bus_write(4'h8, 32'h2);
    n_checks++;
    if (frame_tick !== 1'b1) $display("FAIL w1c_ovr_align: got %b want 1", frame_tick);
    else n_pass++;
    bus_read(4'h8, d);
    n_checks++;
    if (d !== status_exp()) $display("FAIL w1c_ovr: got %0h want %0h", d, status_exp());
    else n_pass++;
    bus_write(4'h0, 32'h0);
    bus_write(4'h8, 32'h3);
    repeat (4) tick();
  endtask

  task automatic test_period_change();
    int p0, p1, r, e, t;
    logic [31:0] d;
    p0 = $urandom_range(3, 6);
    p1 = $urandom_range(1, 3);
    bus_write(4'h4, 32'(p0));
    bus_write(4'h0, 32'h1);
    e = cyc + 2 + p0 * Div;
    wait_tick(p0 * Div + 8, t);
    n_checks++;
    if (t !== e) $display("FAIL pchg_first: got cycle %0d want %0d", t, e); else n_pass++;
    r = $urandom_range(0, p0 * Div - 3);
    wait_until(t + r);
    bus_write(4'h4, 32'(p1));
    e = t + p0 * Div;
    wait_tick(p0 * Div + 8, t);
    n_checks++;
    if (t !== e) $display("FAIL pchg_cur_frame: got cycle %0d want %0d", t, e); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      e = e + p1 * Div;
      wait_tick(p0 * Div + 8, t);
      n_checks++;
      if (t !== e) $display("FAIL pchg_new_frame: got cycle %0d want %0d", t, e); else n_pass++;
    end
    bus_read(4'h4, d);
    n_checks++;
    if (d !== 32'(p1)) $display("FAIL pchg_readback: got %0d want %0d", d, p1); else n_pass++;
    bus_write(4'h0, 32'h0);
    bus_write(4'h8, 32'h3);
    repeat (4) tick();
  endtask

  task automatic test_en_clear();
    int p, r, e, t;
    logic [31:0] d;
    p = $urandom_range(2, 5);
    bus_write(4'h4, 32'(p));
    bus_write(4'h0, 32'h1);
    e = cyc + 2 + p * Div;
    wait_tick(p * Div + 8, t);
    n_checks++;
    if (t !== e) $display("FAIL en_first: got cycle %0d want %0d", t, e); else n_pass++;
    r = $urandom_range(0, p * Div - 3);
    wait_until(t + r);
    bus_write(4'h0, 32'h0);
    wait_tick(3 * p * Div, t);
    n_checks++;
    if (t !== -1) $display("FAIL en_off_tick: got tick at cycle %0d want none", t); else n_pass++;
    bus_read(4'h8, d);
    n_checks++;
    if (d !== status_exp()) $display("FAIL en_off_status: got %0h want %0h", d, status_exp());
    else n_pass++;
    bus_read(4'hC, d);
    n_checks++;
    if (d !== fcnt_exp()) $display("FAIL en_off_fcnt: got %0d want %0d", d, fcnt_exp());
    else n_pass++;
    bus_write(4'h0, 32'h1);
    e = cyc + 2 + p * Div;
    wait_tick(p * Div + 8, t);
    n_checks++;
    if (t !== e) $display("FAIL en_rearm: got cycle %0d want %0d", t, e); else n_pass++;
    bus_write(4'h0, 32'h0);
    bus_write(4'h8, 32'h3);
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    int p, e, t;
    logic [31:0] d;
    p = $urandom_range(2, 5);
    bus_write(4'h4, 32'(p));
    bus_write(4'h0, 32'h3);
    e = cyc + 2 + p * Div;
    wait_tick(p * Div + 8, t);
    n_checks++;
    if (t !== e) $display("FAIL rmid_tick: got cycle %0d want %0d", t, e); else n_pass++;
    n_checks++;
    if (frame_irq !== 1'b0) $display("FAIL rmid_irq_lag: got %b want 0", frame_irq); else n_pass++;
    tick();
    n_checks++;
    if (frame_irq !== 1'b1) $display("FAIL rmid_irq: got %b want 1", frame_irq); else n_pass++;
    wait_until(cyc + $urandom_range(0, p * Div - 3));
    #2;
    HRESETn = 1'b0;
    #1;
    n_checks++;
    if (frame_irq !== 1'b0) $display("FAIL rmid_rst_irq: got %b want 0", frame_irq); else n_pass++;
    n_checks++;
    if (HRDATA !== 32'd0) $display("FAIL rmid_rst_hrdata: got %0h want 0", HRDATA); else n_pass++;
    n_checks++;
    if (frame_tick !== 1'b0) $display("FAIL rmid_rst_tick: got %b want 0", frame_tick);
    else n_pass++;
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    bus_read(4'hC, d);
    n_checks++;
    if (d !== fcnt_exp()) $display("FAIL rmid_fcnt: got %0d want %0d", d, fcnt_exp());
    else n_pass++;
    n_checks++;
    if (d !== 32'd0) $display("FAIL rmid_fcnt_zero: got %0d want 0", d); else n_pass++;
    bus_read(4'h4, d);
    n_checks++;
    if (d !== 32'(PeriodRst)) $display("FAIL rmid_period: got %0d want %0d", d, PeriodRst);
    else n_pass++;
    bus_read(4'h0, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL rmid_ctrl: got %0h want 0", d); else n_pass++;
    wait_tick(3 * p * Div, t);
    n_checks++;
    if (t !== -1) $display("FAIL rmid_no_tick: got tick at cycle %0d want none", t); else n_pass++;
  endtask

  initial begin
    HRESETn = 1'b0;
    HSEL    = 1'b0;
    HWRITE  = 1'b0;
    HTRANS  = 2'b00;
    HADDR   = 4'h0;
    HWDATA  = 32'd0;
    test_reset();
    test_frame_rate();
    test_overrun();
    test_w1c_collision();
    test_period_change();
    test_en_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: still running at cycle %0d, limit 100000 cycles", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
